// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the ID-stage forwarding / load-use hazard unit.
// Stall-bus index, FSM state encodings and counter sizing.
package fwd_hazard_unit_pkg;

  localparam int STALL_ID = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Counter must hold LOAD_LAT-1; keep at least one bit for LOAD_LAT=1.
  function automatic int cnt_width(input int load_lat);
    return (load_lat < 1) ? 1 : $clog2(load_lat + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bus bundle between the pipeline and the forwarding unit.
// The master side drives read ports and write-back sources; the slave returns forwarding results.
interface fwd_hazard_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int STALL_W = 6
);
  logic                     flush;
  logic [STALL_W-1:0]       stall;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic                     ex_we;
  logic [ADDR_W-1:0]        ex_waddr;
  logic [DATA_W-1:0]        ex_wdata;
  logic                     ex_is_load;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     wb_we;
  logic [ADDR_W-1:0]        wb_waddr;
  logic [DATA_W-1:0]        wb_wdata;
  logic [NUM_RD-1:0]        fwd_sel;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic                     stall_req;

  modport master (
    output flush, stall, rd_en, rd_addr,
    output ex_we, ex_waddr, ex_wdata, ex_is_load,
    output mem_we, mem_waddr, mem_wdata,
    output wb_we, wb_waddr, wb_wdata,
    input  fwd_sel, fwd_data, stall_req
  );

  modport slave (
    input  flush, stall, rd_en, rd_addr,
    input  ex_we, ex_waddr, ex_wdata, ex_is_load,
    input  mem_we, mem_waddr, mem_wdata,
    input  wb_we, wb_waddr, wb_wdata,
    output fwd_sel, fwd_data, stall_req
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_port_sel.sv
// One ID read port: EX > MEM > WB > hold priority mux, plus a hold register
// that keeps a MEM/WB value alive while ID is stalled and the producer drains away.
module fwd_port_sel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_hold,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              sel,
  output logic [DATA_W-1:0] data,
  output logic              load_hit
);

  logic              rd_live;
  logic              ex_hit;
  logic              mem_hit;
  logic              wb_hit;
  logic              hold_hit;
  logic              capture;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  // r0 is hard-wired zero, so it never matches any producer.
  assign rd_live  = rd_en && (rd_addr != '0);
  assign ex_hit   = rd_live && ex_we  && (ex_waddr  == rd_addr);
  assign mem_hit  = rd_live && mem_we && (mem_waddr == rd_addr);
  assign wb_hit   = rd_live && wb_we  && (wb_waddr  == rd_addr);
  assign hold_hit = rd_live && hold_valid && (hold_addr == rd_addr);
  assign load_hit = ex_hit && ex_is_load;
  assign capture  = id_hold && (mem_hit || wb_hit);

  always_comb begin
    sel  = 1'b0;
    data = '0;
    if (ex_hit && !ex_is_load) begin
      sel  = 1'b1;
      data = ex_wdata;
    end else if (mem_hit) begin
      sel  = 1'b1;
      data = mem_wdata;
    end else if (wb_hit) begin
      sel  = 1'b1;
      data = wb_wdata;
    end else if (hold_hit) begin
      sel  = 1'b1;
      data = hold_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
    end else if (!id_hold) begin
      hold_valid <= 1'b0;
    end
  end

  // Payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture && !flush) begin
      hold_addr <= rd_addr;
      hold_data <= mem_hit ? mem_wdata : wb_wdata;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit: NUM_RD forwarding ports plus a
// stall FSM that holds ID for LOAD_LAT cycles when a read depends on a load in EX.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int LOAD_LAT = 1,
  parameter int STALL_W  = 6
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_RD-1:0]        load_hit;
  logic [NUM_RD-1:0]        sel_vec;
  logic [NUM_RD*DATA_W-1:0] data_vec;
  logic                     hazard;
  logic                     stall_int;
  logic                     id_hold;

  assign hazard    = |load_hit;
  assign stall_int = (state == ST_WAIT) || hazard;
  assign id_hold   = bus.stall[STALL_ID] || stall_int;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_sel (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .id_hold    (id_hold),
      .rd_en      (bus.rd_en[i]),
      .rd_addr    (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .ex_we      (bus.ex_we),
      .ex_waddr   (bus.ex_waddr),
      .ex_wdata   (bus.ex_wdata),
      .ex_is_load (bus.ex_is_load),
      .mem_we     (bus.mem_we),
      .mem_waddr  (bus.mem_waddr),
      .mem_wdata  (bus.mem_wdata),
      .wb_we      (bus.wb_we),
      .wb_waddr   (bus.wb_waddr),
      .wb_wdata   (bus.wb_wdata),
      .sel        (sel_vec[i]),
      .data       (data_vec[i*DATA_W +: DATA_W]),
      .load_hit   (load_hit[i])
    );
  end

  // With LOAD_LAT=1 the load reaches MEM next cycle, so IDLE never leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state <= ST_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

  assign bus.fwd_sel   = rst ? '0   : sel_vec;
  assign bus.fwd_data  = rst ? '0   : data_vec;
  assign bus.stall_req = rst ? 1'b0 : stall_int;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and
// are compared every cycle against a remaining-stall-cycles / hold-table reference model.
module tb_fwd_hazard_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_RD  = 2;
  localparam int STALL_W = 6;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fwd_hazard_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .STALL_W(STALL_W)) if1 ();
  fwd_hazard_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .STALL_W(STALL_W)) if3 ();

  assign if3.flush      = if1.flush;
  assign if3.stall      = if1.stall;
  assign if3.rd_en      = if1.rd_en;
  assign if3.rd_addr    = if1.rd_addr;
  assign if3.ex_we      = if1.ex_we;
  assign if3.ex_waddr   = if1.ex_waddr;
  assign if3.ex_wdata   = if1.ex_wdata;
  assign if3.ex_is_load = if1.ex_is_load;
  assign if3.mem_we     = if1.mem_we;
  assign if3.mem_waddr  = if1.mem_waddr;
  assign if3.mem_wdata  = if1.mem_wdata;
  assign if3.wb_we      = if1.wb_we;
  assign if3.wb_waddr   = if1.wb_waddr;
  assign if3.wb_wdata   = if1.wb_wdata;

  fwd_hazard_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .LOAD_LAT(1), .STALL_W(STALL_W))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  fwd_hazard_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .LOAD_LAT(3), .STALL_W(STALL_W))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 is LOAD_LAT=1, index 1 is LOAD_LAT=3.
  int          rem [2];
  logic        hv  [2][NUM_RD];
  logic [4:0]  ha  [2][NUM_RD];
  logic [31:0] hd  [2][NUM_RD];

  function automatic int lat_of(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rem[m] = 0;
      for (int i = 0; i < NUM_RD; i++) hv[m][i] = 1'b0;
    end
  endtask

  task automatic eval(input int m, output logic [1:0] s, output logic [63:0] d,
                      output logic sr, output logic hz);
    logic [4:0] a;
    logic       en;
    s  = '0;
    d  = '0;
    hz = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      a  = if1.rd_addr[i*5 +: 5];
      en = if1.rd_en[i] && (a != 5'd0);
      if (en && if1.ex_we && if1.ex_waddr == a && if1.ex_is_load) hz = 1'b1;
      if (en && if1.ex_we && if1.ex_waddr == a && !if1.ex_is_load) begin
        s[i] = 1'b1; d[i*32 +: 32] = if1.ex_wdata;
      end else if (en && if1.mem_we && if1.mem_waddr == a) begin
        s[i] = 1'b1; d[i*32 +: 32] = if1.mem_wdata;
      end else if (en && if1.wb_we && if1.wb_waddr == a) begin
        s[i] = 1'b1; d[i*32 +: 32] = if1.wb_wdata;
      end else if (en && hv[m][i] && ha[m][i] == a) begin
        s[i] = 1'b1; d[i*32 +: 32] = hd[m][i];
      end
    end
    sr = (rem[m] > 0) || hz;
  endtask

  task automatic model_clock(input int m);
    logic [1:0]  s;
    logic [63:0] d;
    logic        sr, hz, held, lm, lw, en;
    logic [4:0]  a;
    eval(m, s, d, sr, hz);
    held = if1.stall[2] || sr;
    if (if1.flush) begin
      rem[m] = 0;
      for (int i = 0; i < NUM_RD; i++) hv[m][i] = 1'b0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        a  = if1.rd_addr[i*5 +: 5];
        en = if1.rd_en[i] && (a != 5'd0);
        lm = en && if1.mem_we && if1.mem_waddr == a;
        lw = en && if1.wb_we && if1.wb_waddr == a;
        if (held && (lm || lw)) begin
          hv[m][i] = 1'b1;
          ha[m][i] = a;
          hd[m][i] = lm ? if1.mem_wdata : if1.wb_wdata;
        end else if (!held) begin
          hv[m][i] = 1'b0;
        end
      end
      if (rem[m] > 0) rem[m] = rem[m] - 1;
      else if (hz) rem[m] = lat_of(m) - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0]  es, os;
    logic [63:0] ed, od, mask;
    logic        esr, osr, hz;
    for (int m = 0; m < 2; m++) begin
      eval(m, es, ed, esr, hz);
      mask = {{32{es[1]}}, {32{es[0]}}};
      if (rst) begin
        es = '0; ed = '0; esr = 1'b0; mask = '1;
      end
      os  = (m == 0) ? if1.fwd_sel   : if3.fwd_sel;
      od  = (m == 0) ? if1.fwd_data  : if3.fwd_data;
      osr = (m == 0) ? if1.stall_req : if3.stall_req;
      chk($sformatf("%s_L%0d_sel", tag, lat_of(m)), {62'd0, os}, {62'd0, es});
      chk($sformatf("%s_L%0d_data", tag, lat_of(m)), od & mask, ed & mask);
      chk($sformatf("%s_L%0d_stall", tag, lat_of(m)), {63'd0, osr}, {63'd0, esr});
    end
  endtask

  // Check combinational outputs late in the cycle, then advance model and clock.
  task automatic cycle(input string tag);
    #3;
    check_outputs(tag);
    if (rst) model_reset();
    else begin
      model_clock(0);
      model_clock(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if1.flush = 1'b0; if1.stall = '0; if1.rd_en = '0; if1.rd_addr = '0;
    if1.ex_we = 1'b0; if1.ex_waddr = '0; if1.ex_wdata = '0; if1.ex_is_load = 1'b0;
    if1.mem_we = 1'b0; if1.mem_waddr = '0; if1.mem_wdata = '0;
    if1.wb_we = 1'b0; if1.wb_waddr = '0; if1.wb_wdata = '0;
  endtask

  task automatic set_rd(input int port, input logic [4:0] a);
    if1.rd_en[port] = 1'b1;
    if1.rd_addr[port*5 +: 5] = a;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b1;
    idle_inputs();
    // Reset: a matching EX write must not leak to the outputs.
    set_rd(0, 5'd4); if1.ex_we = 1'b1; if1.ex_waddr = 5'd4; if1.ex_wdata = 32'h1234;
    #2;
    chk("reset_sel", {62'd0, if1.fwd_sel}, 64'd0);
    cycle("reset");
    cycle("reset2");
    rst = 1'b0;
    idle_inputs();
    cycle("idle");

    // Chain priority EX > MEM > WB.
    set_rd(0, 5'd5);
    if1.ex_we  = 1'b1; if1.ex_waddr  = 5'd5; if1.ex_wdata  = 32'h11;
    if1.mem_we = 1'b1; if1.mem_waddr = 5'd5; if1.mem_wdata = 32'h22;
    if1.wb_we  = 1'b1; if1.wb_waddr  = 5'd5; if1.wb_wdata  = 32'h33;
    #2;
    chk("chain_ex_data", {32'd0, if1.fwd_data[31:0]}, 64'h11);
    cycle("chain_ex");
    if1.ex_we = 1'b0;
    #2;
    chk("chain_mem_data", {32'd0, if1.fwd_data[31:0]}, 64'h22);
    cycle("chain_mem");

    // r0 is never forwarded.
    idle_inputs();
    set_rd(1, 5'd0);
    if1.ex_we  = 1'b1; if1.ex_waddr  = 5'd0; if1.ex_wdata  = 32'hFFFF_FFFF;
    if1.mem_we = 1'b1; if1.mem_waddr = 5'd0; if1.mem_wdata = 32'hFFFF_FFFF;
    if1.wb_we  = 1'b1; if1.wb_waddr  = 5'd0; if1.wb_wdata  = 32'hFFFF_FFFF;
    #2;
    chk("r0_sel1", {63'd0, if1.fwd_sel[1]}, 64'd0);
    chk("r0_stall", {63'd0, if1.stall_req}, 64'd0);
    cycle("r0");

    // Load-use: one-cycle stall at LOAD_LAT=1, three cycles at LOAD_LAT=3.
    idle_inputs();
    set_rd(0, 5'd8);
    if1.ex_we = 1'b1; if1.ex_waddr = 5'd8; if1.ex_is_load = 1'b1;
    #2;
    chk("ld_l1_stall_c1", {63'd0, if1.stall_req}, 64'd1);
    chk("ld_l3_stall_c1", {63'd0, if3.stall_req}, 64'd1);
    cycle("ld_c1");
    if1.ex_we = 1'b0; if1.ex_is_load = 1'b0;
    if1.mem_we = 1'b1; if1.mem_waddr = 5'd8; if1.mem_wdata = 32'hCAFE;
    #2;
    chk("ld_l1_stall_c2", {63'd0, if1.stall_req}, 64'd0);
    chk("ld_l1_fwd_c2", {32'd0, if1.fwd_data[31:0]}, 64'hCAFE);
    chk("ld_l3_stall_c2", {63'd0, if3.stall_req}, 64'd1);
    cycle("ld_c2");
    if1.mem_we = 1'b0;
    #2;
    chk("ld_l3_stall_c3", {63'd0, if3.stall_req}, 64'd1);
    cycle("ld_c3");
    #2;
    chk("ld_l3_stall_c4", {63'd0, if3.stall_req}, 64'd0);
    cycle("ld_c4");
    cycle("ld_c5");

    // Flush during WAIT ends the stall on the next cycle.
    idle_inputs();
    set_rd(1, 5'd8);
    if1.ex_we = 1'b1; if1.ex_waddr = 5'd8; if1.ex_is_load = 1'b1;
    cycle("fl_c1");
    if1.ex_we = 1'b0; if1.ex_is_load = 1'b0; if1.flush = 1'b1;
    #2;
    chk("fl_l3_stall_c2", {63'd0, if3.stall_req}, 64'd1);
    cycle("fl_c2");
    if1.flush = 1'b0;
    #2;
    chk("fl_l3_stall_c3", {63'd0, if3.stall_req}, 64'd0);
    cycle("fl_c3");

    // Hold register keeps a WB value alive across an ID stall.
    idle_inputs();
    if1.stall[2] = 1'b1;
    set_rd(1, 5'd9);
    if1.wb_we = 1'b1; if1.wb_waddr = 5'd9; if1.wb_wdata = 32'hBEEF;
    #2;
    chk("hold_c1", {if1.fwd_sel[1], if1.fwd_data[63:32]}, {1'b1, 32'hBEEF});
    cycle("hold_c1");
    if1.wb_we = 1'b0;
    #2;
    chk("hold_c2", {if1.fwd_sel[1], if1.fwd_data[63:32]}, {1'b1, 32'hBEEF});
    cycle("hold_c2");
    #2;
    chk("hold_c3", {if1.fwd_sel[1], if1.fwd_data[63:32]}, {1'b1, 32'hBEEF});
    cycle("hold_c3");
    if1.stall[2] = 1'b0;
    #2;
    chk("hold_adv", {if1.fwd_sel[1], if1.fwd_data[63:32]}, {1'b1, 32'hBEEF});
    cycle("hold_adv");
    #2;
    chk("hold_cleared", {63'd0, if1.fwd_sel[1]}, 64'd0);
    cycle("hold_after");

    // Async reset while LOAD_LAT=3 instance sits in WAIT.
    idle_inputs();
    set_rd(0, 5'd7);
    if1.ex_we = 1'b1; if1.ex_waddr = 5'd7; if1.ex_is_load = 1'b1;
    cycle("ar_c1");
    idle_inputs();
    set_rd(0, 5'd7);
    if1.mem_we = 1'b1; if1.mem_waddr = 5'd7; if1.mem_wdata = 32'h77;
    #2;
    chk("ar_wait_stall", {63'd0, if3.stall_req}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_stall_now", {63'd0, if3.stall_req}, 64'd0);
    chk("ar_sel_now", {62'd0, if3.fwd_sel}, 64'd0);
    model_reset();
    cycle("ar_hold");
    rst = 1'b0;
    idle_inputs();
    cycle("ar_post");

    // Randomized traffic on a small register window to force frequent matches.
    for (int n = 0; n < 400; n++) begin
      if1.rd_en      = 2'($urandom_range(3, 0));
      if1.rd_addr    = {5'($urandom_range(3, 0)), 5'($urandom_range(3, 0))};
      if1.ex_we      = 1'($urandom_range(1, 0));
      if1.ex_waddr   = 5'($urandom_range(3, 0));
      if1.ex_wdata   = $urandom;
      if1.ex_is_load = ($urandom_range(3, 0) == 0);
      if1.mem_we     = 1'($urandom_range(1, 0));
      if1.mem_waddr  = 5'($urandom_range(3, 0));
      if1.mem_wdata  = $urandom;
      if1.wb_we      = 1'($urandom_range(1, 0));
      if1.wb_waddr   = 5'($urandom_range(3, 0));
      if1.wb_wdata   = $urandom;
      if1.stall      = 6'($urandom_range(63, 0));
      if1.stall[2]   = ($urandom_range(2, 0) == 0);
      if1.flush      = ($urandom_range(19, 0) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the ID stage of the 5-stage pipeline. Generalises single-pair rs/rt forwarding to NUM_RD read ports and three write-back sources (EX, MEM, WB).
- Adds a multi-cycle load-use stall counter for slow data memory.
- Adds per-port hold registers, so forwarded values survive ID stalls while the producer drains out of the pipeline.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_RD, 2, number of ID read ports
- LOAD_LAT, 1, cycles from load in EX until its data is valid on mem_wdata (1..7)
- STALL_W, 6, width of pipeline stall bus

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush; clears all internal state
- stall  in  STALL_W  pipeline stall bus; stall[2]=1 means the ID stage holds this cycle
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  per-port read address; port i at [i*ADDR_W +: ADDR_W]
- ex_we  in  1  EX write enable
- ex_waddr  in  ADDR_W  EX destination
- ex_wdata  in  DATA_W  EX result
- ex_is_load  in  1  EX instruction is a load
- mem_we  in  1  MEM write enable
- mem_waddr  in  ADDR_W  MEM destination
- mem_wdata  in  DATA_W  MEM result or load data
- wb_we  in  1  WB write enable
- wb_waddr  in  ADDR_W  WB destination
- wb_wdata  in  DATA_W  WB data
- fwd_sel  out  NUM_RD  per-port: use fwd_data instead of the register file
- fwd_data  out  NUM_RD*DATA_W  per-port forwarded value
- stall_req  out  1  load-use stall request to the stall controller

Behaviour:
- Reset (async, rst=1): state IDLE, wait counter 0, all hold_valid 0. Outputs are forced 0 while rst is high: fwd_sel=0, fwd_data=0, stall_req=0.
- Match rule, per port i, per source s: rd_en[i] & s_we & s_waddr==rd_addr[i] & rd_addr[i]!=0. Register 0 is never forwarded and never stalls.
- Forward priority (combinational, same cycle): EX > MEM > WB > hold register > none.
  - An EX match whose ex_is_load=1 does not forward; it raises a hazard instead.
  - fwd_sel[i]=1 iff any source selected.
- Load-use hazard: any port matching EX with ex_is_load=1.
- FSM states: IDLE, WAIT.
  - IDLE: a hazard drives stall_req=1 combinationally.
    - LOAD_LAT=1: stay IDLE. The load reaches MEM next cycle and is forwarded from mem_wdata.
    - LOAD_LAT>1: go to WAIT with cnt=LOAD_LAT-1.
  - WAIT: stall_req=1 and cnt decrements each cycle.
    - When cnt reaches 1, the next state is IDLE.
    - In WAIT, EX holds a bubble. A new hazard cannot arise in WAIT, so it is ignored.
- Hold registers, per port i:
  - Capture condition: any live MEM/WB match while (stall[2] | stall_req).
  - On capture: hold_data[i] <= selected live value, hold_addr[i] <= rd_addr[i], hold_valid[i] <= 1.
  - A newer capture overwrites an older one.
  - A hold is used only while hold_addr[i]==rd_addr[i].
  - hold_valid cleared on the first edge where ID advances (stall[2]=0 & stall_req=0).
- Simultaneous events:
  - flush beats capture and the counter: next state IDLE, cnt 0, hold_valid all 0.
  - A live match beats a hold even in the capture cycle; the capture stores the live value.
- Widths: all compares are ADDR_W-bit equality; there is no arithmetic on data.

Decomposition:
- Shared package (defines include): stall-bus bit index for ID, FSM state encodings, counter width clog2(LOAD_LAT+1).
- One natural sub-module: fwd_port_sel, the per-port priority mux and hold register, generated NUM_RD times.
- FSM and counter live in the top level.

Test Plan:
- Chain priority: EX writes r5=0x11, MEM r5=0x22, WB r5=0x33, port0 reads r5 -> fwd_sel[0]=1, data 0x11. Drop ex_we -> 0x22.
- r0 protection: all sources write r0=0xFFFF_FFFF, port1 reads r0 -> fwd_sel[1]=0, stall_req=0.
- Load-use at LOAD_LAT=1: load to r8 in EX, port0 reads r8 -> stall_req=1 one cycle. Next cycle mem_wdata=0xCAFE -> fwd 0xCAFE, stall_req=0.
- LOAD_LAT=3: same hazard -> stall_req high exactly 3 cycles, then IDLE. Inject flush in cycle 2 -> stall_req=0 next cycle.
- Hold across stall: stall[2]=1 for 3 cycles while WB writes r9=0xBEEF in cycle 1 only, port1 reads r9 -> fwd data 0xBEEF in cycles 1-3 and on the advance cycle. The hold is cleared after the advance.
- Async reset mid-WAIT: assert rst between edges -> stall_req, fwd_sel go 0 immediately; after release the FSM is IDLE.
